cargador_instrucciones: RTL and testbench
=========================================

CARGADOR_INSTRUCCIONES -- requirements
Module: cargador_instrucciones

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the instruction-word and address width.
REQ-002 The block SHALL have parameter CELDAS, default 256, giving the number of instruction-memory cells (byte-addressed, word stride 4).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_Start, input, 1 bit: a one-cycle pulse that starts a program load.
REQ-006 The block SHALL have port i_RxDato, input, 8 bits: received UART byte.
REQ-007 The block SHALL have port i_RxDone, input, 1 bit: one-cycle strobe marking i_RxDato valid.
REQ-008 The block SHALL have port o_DirecDebug, output, NBITS: instruction-memory write address.
REQ-009 The block SHALL have port o_DatoDebug, output, NBITS: instruction-memory write data.
REQ-010 The block SHALL have port o_WriteDebug, output, 1 bit: memory write strobe; memory samples on its rising edge.
REQ-011 The block SHALL have port o_Cargando, output, 1 bit: high while a load is in progress.
REQ-012 The block SHALL have port o_Listo, output, 1 bit: high once a load has completed.
REQ-013 The block SHALL have port o_Overflow, output, 1 bit: high when a load ended because memory was full.
REQ-014 The block SHALL have port o_Palabras, output, NBITS: count of words written in the current or last load.

Function
REQ-015 The block SHALL implement the states IDLE, RECV, SETUP, WRITE and DONE, all registered.
REQ-016 IDLE SHALL move to RECV on i_Start; while in IDLE, i_RxDone SHALL be ignored.
REQ-017 On entering RECV from IDLE or DONE, the block SHALL clear the byte counter, the address (0), o_Palabras and o_Overflow.
REQ-018 In RECV, each i_RxDone SHALL shift i_RxDato into a 32-bit assembly register, MSB first (first byte = bits 31:24).
REQ-019 When the fourth byte is accepted, the block SHALL move to SETUP on the next cycle and reset the byte counter to 0.
REQ-020 In SETUP, o_DatoDebug SHALL hold the assembled word and o_DirecDebug the current address, with o_WriteDebug = 0; duration 1 cycle.
REQ-021 In WRITE, o_WriteDebug SHALL be 1 for exactly 1 cycle, with address and data unchanged from SETUP.
REQ-022 Address and data SHALL stay stable for at least 1 cycle after o_WriteDebug falls.
REQ-023 On leaving WRITE, o_Palabras SHALL increment by 1.
REQ-024 On leaving WRITE, if the written word equals 0xFFFFFFFF (halt), the block SHALL go to DONE; the halt word is itself written.
REQ-025 On leaving WRITE, otherwise, if the address equals CELDAS-4, the block SHALL go to DONE and set o_Overflow = 1.
REQ-026 On leaving WRITE, in all other cases, the address SHALL increase by 4 and the block SHALL return to RECV.
REQ-027 A halt word written at address CELDAS-4 SHALL end the load with o_Overflow = 0 (halt takes priority).
REQ-028 i_RxDone asserted in SETUP, WRITE or DONE SHALL be ignored, with no data loss requirement; the UART byte period far exceeds 2 cycles.
REQ-029 i_Start SHALL be ignored in RECV, SETUP and WRITE.
REQ-030 i_Start in DONE SHALL restart the load: go to RECV and apply REQ-017.
REQ-031 o_Cargando SHALL be 1 in RECV, SETUP and WRITE, and 0 otherwise.
REQ-032 o_Listo SHALL be 1 only in DONE.
REQ-033 A partial word (1 to 3 bytes) SHALL remain held in RECV indefinitely; the block SHALL have no timeout.
REQ-034 The byte counter SHALL be 2 bits wide and wrap from 3 to 0.

Reset
REQ-035 While i_reset = 1 at a clock edge, the state SHALL become IDLE.
REQ-036 While i_reset = 1 at a clock edge, all outputs SHALL become 0: o_DirecDebug, o_DatoDebug, o_WriteDebug, o_Cargando, o_Listo, o_Overflow, o_Palabras.
REQ-037 While i_reset = 1 at a clock edge, the assembly register and byte counter SHALL be cleared.
REQ-038 Reset SHALL take priority over i_Start and i_RxDone.
REQ-039 Reset asserted during SETUP or WRITE SHALL drop o_WriteDebug to 0 on that edge, and no further write pulse SHALL occur.

Verification
REQ-040 Load one word: reset, i_Start, then bytes 0x00,0x22,0x08,0x20 -> one o_WriteDebug pulse with address 0 and data 0x00220820, preceded by a 1-cycle setup with stable data; block returns to RECV with o_Palabras = 1.
REQ-041 Halt ends load: words 0x8C010004 then 0xFFFFFFFF -> writes at addresses 0 and 4, then o_Listo = 1, o_Overflow = 0, o_Palabras = 2, o_Cargando = 0.
REQ-042 Memory full: 64 non-halt words with CELDAS = 256 -> last write at address 252, then DONE with o_Overflow = 1 and o_Palabras = 64.
REQ-043 Ignored strobes: i_RxDone pulses in IDLE, and a second i_Start in RECV after 2 bytes -> no effect; the next 2 bytes complete the word correctly.
REQ-044 Reset mid-write: assert i_reset in the WRITE cycle -> o_WriteDebug = 0 on the next edge, state IDLE, all outputs 0, and no write pulse until a new i_Start and 4 new bytes.
REQ-045 Restart: i_Start in DONE -> address 0, o_Palabras = 0, o_Overflow = 0; the next word is written at address 0.

Source files
------------

// File: rtl/cargador_instrucciones_if.sv
// Loader bus: UART byte stream and start pulse in,
// instruction-memory write port and load status out.
interface cargador_instrucciones_if #(
    parameter int NBITS = 32
);
    logic             i_Start;
    logic [7:0]       i_RxDato;
    logic             i_RxDone;
    logic [NBITS-1:0] o_DirecDebug;
    logic [NBITS-1:0] o_DatoDebug;
    logic             o_WriteDebug;
    logic             o_Cargando;
    logic             o_Listo;
    logic             o_Overflow;
    logic [NBITS-1:0] o_Palabras;

    modport master (
        output i_Start, i_RxDato, i_RxDone,
        input  o_DirecDebug, o_DatoDebug, o_WriteDebug,
        input  o_Cargando, o_Listo, o_Overflow, o_Palabras
    );

    modport slave (
        input  i_Start, i_RxDato, i_RxDone,
        output o_DirecDebug, o_DatoDebug, o_WriteDebug,
        output o_Cargando, o_Listo, o_Overflow, o_Palabras
    );
endinterface

// File: rtl/cargador_instrucciones.sv
// Program loader: packs UART bytes MSB-first into words and writes
// them to instruction memory until a halt word or memory is full.
module cargador_instrucciones #(
    parameter int NBITS  = 32,
    parameter int CELDAS = 256
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    cargador_instrucciones_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RECV  = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [NBITS-1:0] LAST = NBITS'(CELDAS - 4);
    localparam logic [NBITS-1:0] STEP = NBITS'(4);
    localparam logic [NBITS-1:0] ONE  = NBITS'(1);

    logic [2:0]       state;
    logic [1:0]       cnt;
    logic [NBITS-1:0] asm_reg;
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] direc;
    logic [NBITS-1:0] dato;
    logic [NBITS-1:0] palabras;
    logic             overflow;
    logic [NBITS-1:0] next_asm;

    assign next_asm = {asm_reg[NBITS-9:0], bus.i_RxDato};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            asm_reg  <= '0;
            addr     <= '0;
            direc    <= '0;
            dato     <= '0;
            palabras <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.i_Start) begin
                        state    <= RECV;
                        cnt      <= 2'd0;
                        addr     <= '0;
                        direc    <= '0;
                        palabras <= '0;
                        overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (bus.i_RxDone) begin
                        asm_reg <= next_asm;
                        cnt     <= cnt + 2'd1;
                        // Latch the write port here so it is stable for all of SETUP.
                        if (cnt == 2'd3) begin
                            state <= SETUP;
                            dato  <= next_asm;
                            direc <= addr;
                        end
                    end
                end
                SETUP: state <= WRITE;
                WRITE: begin
                    palabras <= palabras + ONE;
                    if (&dato) begin
                        state <= DONE;
                    end else if (addr == LAST) begin
                        state    <= DONE;
                        overflow <= 1'b1;
                    end else begin
                        addr  <= addr + STEP;
                        state <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write port (direc/dato) only moves at the next word or a restart,
    // so it holds well past the fall of the strobe.
    assign bus.o_DirecDebug = direc;
    assign bus.o_DatoDebug  = dato;
    assign bus.o_WriteDebug = (state == WRITE);
    assign bus.o_Cargando   = (state == RECV) || (state == SETUP) ||
                              (state == WRITE);
    assign bus.o_Listo      = (state == DONE);
    assign bus.o_Overflow   = overflow;
    assign bus.o_Palabras   = palabras;
endmodule

// File: tb/tb_cargador_instrucciones.sv
// Bench for cargador_instrucciones: vector table of loads plus
// hand-written ignore, overflow and reset-mid-write sequences.
module tb_cargador_instrucciones;
    logic clk;
    logic rst;

    cargador_instrucciones_if #(.NBITS(32)) bus ();

    cargador_instrucciones #(.NBITS(32), .CELDAS(256)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic [31:0] word;
        logic [31:0] addr;
        logic [31:0] pal;
        logic        listo;
        logic        ovf;
        logic        carg;
    } vec_t;

    vec_t        tbl [5];
    logic [63:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    logic        prev_w = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_d = '0;
    logic [63:0] last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.i_Start = 1'b1;
        cyc();
        bus.i_Start = 1'b0;
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_RxDato = b;
        bus.i_RxDone = 1'b1;
        cyc();
        bus.i_RxDone = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8]);
        end
    endtask

    task automatic chk_status(input string tag, input logic [31:0] pal,
                              input logic listo, input logic ovf,
                              input logic carg);
        chk({tag, "_palabras"}, bus.o_Palabras, pal);
        chk({tag, "_listo"}, 32'(bus.o_Listo), 32'(listo));
        chk({tag, "_overflow"}, 32'(bus.o_Overflow), 32'(ovf));
        chk({tag, "_cargando"}, 32'(bus.o_Cargando), 32'(carg));
    endtask

    task automatic chk_all_zero(input string tag);
        chk_status(tag, 32'd0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_write"}, 32'(bus.o_WriteDebug), 32'd0);
        chk({tag, "_direc"}, bus.o_DirecDebug, 32'd0);
        chk({tag, "_dato"}, bus.o_DatoDebug, 32'd0);
    endtask

    // Write-port monitor: each strobe must match the scoreboard head,
    // be preceded by a quiet setup cycle and followed by a hold cycle.
    always @(negedge clk) begin
        if (bus.o_WriteDebug) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required=no write",
                         bus.o_DirecDebug, bus.o_DatoDebug);
            end else begin
                last_exp = sb.pop_front();
                chk("wr_addr", bus.o_DirecDebug, last_exp[63:32]);
                chk("wr_data", bus.o_DatoDebug, last_exp[31:0]);
                chk("setup_we", 32'(prev_w), 32'd0);
                chk("setup_addr", prev_a, last_exp[63:32]);
                chk("setup_data", prev_d, last_exp[31:0]);
            end
        end else if (prev_w && !rst) begin
            chk("hold_addr", bus.o_DirecDebug, last_exp[63:32]);
            chk("hold_data", bus.o_DatoDebug, last_exp[31:0]);
        end
        prev_w <= bus.o_WriteDebug;
        prev_a <= bus.o_DirecDebug;
        prev_d <= bus.o_DatoDebug;
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0022_0820, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 32'h8C01_0004, 32'd4, 32'd2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'd8, 32'd3, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'hDEAD_BEEF, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'd4, 32'd2, 1'b1, 1'b0, 1'b0};

        rst          = 1'b1;
        bus.i_Start  = 1'b0;
        bus.i_RxDato = 8'h00;
        bus.i_RxDone = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk_all_zero("reset");
        cyc();
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].start) pulse_start();
            sb.push_back({tbl[i].addr, tbl[i].word});
            send_word(tbl[i].word);
            @(negedge clk);
            chk_status($sformatf("vec%0d", i), tbl[i].pal, tbl[i].listo,
                       tbl[i].ovf, tbl[i].carg);
        end

        pulse_start();
        for (int i = 0; i < 64; i++) begin
            sb.push_back({32'(4 * i), 32'h1000_0000 + 32'(i * 3)});
            send_word(32'h1000_0000 + 32'(i * 3));
        end
        @(negedge clk);
        chk_status("full", 32'd64, 1'b1, 1'b1, 1'b0);

        pulse_start();
        @(negedge clk);
        chk_status("restart", 32'd0, 1'b0, 1'b0, 1'b1);
        chk("restart_direc", bus.o_DirecDebug, 32'd0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        send_byte(8'hAA);
        send_byte(8'h55);
        @(negedge clk);
        chk_all_zero("idle_rx");

        pulse_start();
        sb.push_back({32'd0, 32'h1122_3344});
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        send_byte(8'h33);
        send_byte(8'h44);
        @(negedge clk);
        chk_status("ign_start", 32'd1, 1'b0, 1'b0, 1'b1);

        sb.push_back({32'd4, 32'hCAFE_F00D});
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        bus.i_RxDato = 8'h0D;
        bus.i_RxDone = 1'b1;
        cyc();
        bus.i_RxDone = 1'b0;
        cyc();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_write");
        cyc();
        rst = 1'b0;
        cyc();
        send_word(32'h5566_7788);
        @(negedge clk);
        chk_status("post_rst", 32'd0, 1'b0, 1'b0, 1'b0);

        pulse_start();
        sb.push_back({32'd0, 32'h0102_0304});
        send_word(32'h0102_0304);
        @(negedge clk);
        chk_status("reload", 32'd1, 1'b0, 1'b0, 1'b1);

        cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
